// File: rtl/aes_mask_pkg.sv
// Shared constants and state encoding for the aes_mask sequencer.
package aes_mask_pkg;

  localparam int unsigned DATA_W          = 128;
  localparam int unsigned ROUNDS_128_DFLT = 10;
  localparam int unsigned ROUNDS_256_DFLT = 14;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StInit    = 3'd1,
    StRound   = 3'd2,
    StFinal   = 3'd3,
    StWaitRes = 3'd4,
    StDone    = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/aes_mask_ctrl_if.sv
// Job request / mask result handshake between the AES core and the mask sequencer.
interface aes_mask_ctrl_if;

  logic                             req_valid;
  logic                             req_ready;
  logic [aes_mask_pkg::DATA_W-1:0]  req_key;
  logic                             req_keylen;
  logic [aes_mask_pkg::DATA_W-1:0]  req_block;
  logic                             res_valid;
  logic                             res_ack;
  logic [aes_mask_pkg::DATA_W-1:0]  res_mask;

  modport master (
    output req_valid, req_key, req_keylen, req_block, res_ack,
    input  req_ready, res_valid, res_mask
  );

  modport slave (
    input  req_valid, req_key, req_keylen, req_block, res_ack,
    output req_ready, res_valid, res_mask
  );

endinterface

// File: rtl/aes_mask_ctrl.sv
// Sequencer driving the aes_mask init/next/finalize strobes for one job at a time.
module aes_mask_ctrl
  import aes_mask_pkg::*;
#(
  parameter int unsigned ROUNDS_128 = ROUNDS_128_DFLT,
  parameter int unsigned ROUNDS_256 = ROUNDS_256_DFLT,
  parameter int unsigned CTR_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  aes_mask_ctrl_if.slave    bus,
  output logic              busy,
  output logic              m_init,
  output logic              m_next,
  output logic              m_finalize,
  output logic [DATA_W-1:0] m_key,
  output logic              m_keylen,
  output logic [DATA_W-1:0] m_block,
  input  logic [DATA_W-1:0] m_result
);

  localparam logic [CTR_W-1:0] CtrOne = CTR_W'(1);

  ctrl_state_e       state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              keylen_q, keylen_d;
  logic [DATA_W-1:0] block_q, block_d;
  logic [DATA_W-1:0] res_mask_q, res_mask_d;
  logic              init_q, next_q, fin_q;

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    key_d      = key_q;
    keylen_d   = keylen_q;
    block_d    = block_q;
    res_mask_d = res_mask_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          key_d    = bus.req_key;
          keylen_d = bus.req_keylen;
          block_d  = bus.req_block;
          ctr_d    = bus.req_keylen ? CTR_W'(ROUNDS_256) : CTR_W'(ROUNDS_128);
          state_d  = StInit;
        end
      end
      StInit:  state_d = StRound;
      StRound: begin
        ctr_d = ctr_q - CtrOne;
        if (ctr_q == CtrOne) state_d = StFinal;
      end
      StFinal: state_d = StWaitRes;
      // Datapath state updated on the finalize edge, so the result is valid here.
      StWaitRes: begin
        res_mask_d = m_result;
        state_d    = StDone;
      end
      StDone: begin
        if (bus.res_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ctr_q      <= '0;
      key_q      <= '0;
      keylen_q   <= 1'b0;
      block_q    <= '0;
      res_mask_q <= '0;
      init_q     <= 1'b0;
      next_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      key_q      <= key_d;
      keylen_q   <= keylen_d;
      block_q    <= block_d;
      res_mask_q <= res_mask_d;
      // Strobes track the state being entered, so they align with the state register.
      init_q     <= (state_d == StInit);
      next_q     <= (state_d == StRound);
      fin_q      <= (state_d == StFinal);
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.res_valid = (state_q == StDone);
  assign bus.res_mask  = res_mask_q;
  assign busy          = (state_q != StIdle);
  assign m_init        = init_q;
  assign m_next        = next_q;
  assign m_finalize    = fin_q;
  assign m_key         = key_q;
  assign m_keylen      = keylen_q;
  assign m_block       = block_q;

endmodule

// File: tb/tb_aes_mask_ctrl.sv
// Self-checking bench for aes_mask_ctrl with a stand-in aes_mask datapath.
module tb_aes_mask_ctrl;
  import aes_mask_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  aes_mask_ctrl_if bus();

  logic              busy, m_init, m_next, m_finalize, m_keylen;
  logic [DATA_W-1:0] m_key, m_block, m_result, dp_q;

  aes_mask_ctrl #(
    .ROUNDS_128 (10),
    .ROUNDS_256 (14),
    .CTR_W      (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .m_init     (m_init),
    .m_next     (m_next),
    .m_finalize (m_finalize),
    .m_key      (m_key),
    .m_keylen   (m_keylen),
    .m_block    (m_block),
    .m_result   (m_result)
  );

  // Stand-in datapath: init loads key, next rotates and mixes, finalize folds in block.
  always @(posedge clk) begin
    if (m_init)          dp_q <= m_key;
    else if (m_next)     dp_q <= {dp_q[126:0], dp_q[127]} ^ 128'h1b;
    else if (m_finalize) dp_q <= dp_q ^ m_block;
  end
  assign m_result = dp_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] key;
    logic         kl;
    logic [127:0] blk;
    int           ack_dly;
    bit           tamper;
    int           exp_n;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [127:0] ref_mask(input logic [127:0] key, input logic kl,
                                            input logic [127:0] blk);
    logic [127:0] x;
    int n;
    n = kl ? 14 : 10;
    x = key;
    for (int i = 0; i < n; i++) x = {x[126:0], x[127]} ^ 128'h1b;
    return x ^ blk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_key    = '0;
    bus.req_keylen = 1'b0;
    bus.req_block  = '0;
    bus.res_ack    = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int w, cyc, init_c, fin_c, nfirst, nlast, ncnt, bad, unstable;
    logic [127:0] mask0;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("ready_before_accept", 128'(bus.req_ready), 128'(1));
    bus.req_valid  = 1'b1;
    bus.req_key    = v.key;
    bus.req_keylen = v.kl;
    bus.req_block  = v.blk;
    bus.res_ack    = (v.ack_dly == 0);
    tick();
    cyc = 1; init_c = -1; fin_c = -1; nfirst = -1; nlast = -1; ncnt = 0; bad = 0;
    while (bus.res_valid !== 1'b1 && cyc < 64) begin
      // Inputs after accept must be ignored; tamper also keeps req_valid asserted.
      bus.req_valid  = v.tamper;
      bus.req_key    = ~v.key;
      bus.req_keylen = ~v.kl;
      bus.req_block  = '1;
      if (m_init) init_c = cyc;
      if (m_finalize) fin_c = cyc;
      if (m_next) begin
        ncnt++;
        if (nfirst < 0) nfirst = cyc;
        nlast = cyc;
      end
      if ((int'(m_init) + int'(m_next) + int'(m_finalize)) > 1) bad++;
      if (bus.req_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick();
      cyc++;
    end
    check("res_valid_latency", 128'(cyc), 128'(v.exp_lat));
    check("init_cycle", 128'(init_c), 128'(1));
    check("next_count", 128'(ncnt), 128'(v.exp_n));
    check("next_first", 128'(nfirst), 128'(2));
    check("next_last", 128'(nlast), 128'(v.exp_n + 1));
    check("finalize_cycle", 128'(fin_c), 128'(v.exp_n + 2));
    check("onehot_busy_ready", 128'(bad), 128'(0));
    check("m_block_held", m_block, v.blk);
    check("m_key_held", m_key, v.key);
    check("m_keylen_held", 128'(m_keylen), 128'(v.kl));
    check("res_mask", bus.res_mask, ref_mask(v.key, v.kl, v.blk));
    mask0 = bus.res_mask;
    unstable = 0;
    for (int i = 0; i < v.ack_dly; i++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_mask !== mask0) unstable++;
    end
    check("done_stable", 128'(unstable), 128'(0));
    bus.req_valid = 1'b0;
    bus.res_ack   = 1'b1;
    tick();
    check("idle_after_ack", 128'({busy, bus.req_ready, bus.res_valid}), 128'(3'b010));
    bus.res_ack = 1'b0;
  endtask

  initial begin
    int errs;
    logic [127:0] key0, blk0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({bus.req_ready, busy, m_init, m_next, m_finalize, bus.res_valid} !== 6'b100000) errs++;
      if (bus.res_mask !== '0 || m_key !== '0 || m_block !== '0 || m_keylen !== 1'b0) errs++;
    end
    check("reset_ctrl", 128'({bus.req_ready, busy, m_init, m_next, m_finalize, bus.res_valid}),
          128'(6'b100000));
    check("reset_res_mask", bus.res_mask, '0);
    check("reset_m_key", m_key, '0);
    check("reset_idle_20", 128'(errs), 128'(0));

    key0 = 128'h000102030405060708090a0b0c0d0e0f;
    blk0 = 128'h00112233445566778899aabbccddeeff;
    vecs[0] = '{key0, 1'b0, blk0, 0, 1'b0, 10, 14};
    vecs[1] = '{key0, 1'b1, blk0, 0, 1'b0, 14, 18};
    vecs[2] = '{key0, 1'b0, blk0, 0, 1'b1, 10, 14};
    vecs[3] = '{~key0, 1'b1, blk0 ^ 128'h5a, 7, 1'b0, 14, 18};
    vecs[4] = '{key0 ^ 128'h77, 1'b0, ~blk0, 0, 1'b0, 10, 14};
    for (int i = 5; i < 8; i++) begin
      vecs[i].key     = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].blk     = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].kl      = 1'($urandom_range(0, 1));
      vecs[i].ack_dly = int'($urandom_range(0, 4));
      vecs[i].tamper  = 1'($urandom_range(0, 1));
      vecs[i].exp_n   = vecs[i].kl ? 14 : 10;
      vecs[i].exp_lat = vecs[i].exp_n + 4;
    end
    for (int i = 0; i < 8; i++) run_job(vecs[i]);

    // Reset in the middle of the round phase, with five next pulses still to go.
    bus.req_valid  = 1'b1;
    bus.req_key    = key0;
    bus.req_keylen = 1'b0;
    bus.req_block  = blk0;
    tick();
    bus.req_valid = 1'b0;
    repeat (6) tick();
    check("mid_round_next", 128'(m_next), 128'(1));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midreset_ctrl", 128'({bus.req_ready, busy, m_init, m_next, m_finalize, bus.res_valid}),
          128'(6'b100000));
    check("midreset_m_key", m_key, '0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({bus.req_ready, m_init, m_next, m_finalize} !== 4'b1000) errs++;
    end
    check("midreset_quiet", 128'(errs), 128'(0));
    run_job(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_mask_ctrl.md
Name: aes_mask_ctrl

Overview:
Sequencer for the aes_mask masking datapath. It accepts one mask-generation job per valid/ready handshake and captures key, keylen and block. It then drives the datapath strobes: one init pulse, keylen-dependent next pulses, and one finalize pulse. It presents the finished mask on a valid/ack output port. It sits between the AES core's control FSM and the aes_mask instance and is the only block that drives the aes_mask strobes.

Parameters:
ROUNDS_128, 10, number of next pulses when keylen = 0
ROUNDS_256, 14, number of next pulses when keylen = 1
CTR_W, 4, round counter width; must hold max(ROUNDS_128, ROUNDS_256)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
req_valid  in  1  job request
req_ready  out  1  controller can accept a job
req_key  in  128  key for the job
req_keylen  in  1  0 = AES-128 schedule, 1 = AES-256 schedule
req_block  in  128  block for the job
res_valid  out  1  mask available on res_mask
res_ack  in  1  consumer takes the mask
res_mask  out  128  registered copy of the mask result
busy  out  1  job in progress (not IDLE)
m_init  out  1  to aes_mask init
m_next  out  1  to aes_mask next
m_finalize  out  1  to aes_mask finalize
m_key  out  128  to aes_mask key (captured register)
m_keylen  out  1  to aes_mask keylen (captured register)
m_block  out  128  to aes_mask block (captured register)
m_result  in  128  from aes_mask result

Behaviour:
- Reset (reset_n = 0 at a posedge): state IDLE; counter 0; key, keylen, block and res_mask registers cleared to 0; m_init, m_next, m_finalize, res_valid and busy all 0; req_ready = 1. The same applies mid-job: the job is abandoned and no further strobe is issued.
- Strobes are registered, one-hot or all zero. At most one of m_init, m_next and m_finalize is high in any cycle.
- m_key, m_keylen and m_block stay stable from the accept edge until the controller next returns to IDLE. The datapath's finalize reads block, so these registers must not change mid-job.
- States: IDLE, INIT, ROUND, FINAL, WAIT_RES, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture the request, load counter = ROUNDS_128 or ROUNDS_256 per req_keylen, and go to INIT.
- INIT: m_init = 1 for one cycle; go to ROUND.
- ROUND:
  - m_next = 1 every cycle; counter decrements.
  - When counter == 1 in this cycle, go to FINAL.
  - Exactly N next pulses are issued.
- FINAL: m_finalize = 1 for one cycle; go to WAIT_RES.
- WAIT_RES: no strobe; capture res_mask <= m_result, because the datapath state register updates on the finalize edge. Go to DONE.
- DONE:
  - res_valid = 1; res_mask is held.
  - On res_ack, go to IDLE (res_valid = 0 the next cycle).
  - A res_ack seen in any other state is ignored.
- Timing: with accept at edge 0, m_init is high in cycle 1, m_next in cycles 2..N+1, and m_finalize in cycle N+2. res_valid rises in cycle N+4 (N+4 cycles after the accept edge).
- req_ready is 0 outside IDLE. A req_valid while busy is not accepted and causes no state change.
- Back-to-back jobs: req_ready returns the cycle after the res_ack edge. There is no overlap between jobs.
- keylen is sampled only at accept. Changes to req_* inputs after accept have no effect.

Decomposition:
- Shared package aes_mask_pkg holds:
  - the state encoding constants;
  - ROUNDS_128 and ROUNDS_256 defaults;
  - the 128-bit width constant.
- No sub-module. Counter and FSM live in one module; aes_mask is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle, 20 cycles → req_ready = 1, all strobes, res_valid, busy and res_mask = 0.
- Job with keylen = 0, key = 000102…0f, block = 00112233…ff, res_ack held 1 → all of the following:
  - m_init pulses 1 cycle after accept;
  - exactly 10 consecutive m_next pulses;
  - 1 m_finalize;
  - res_valid 14 cycles after accept;
  - res_mask equals the reference model of aes_mask.
- Same job with keylen = 1 → 14 m_next pulses; res_valid 18 cycles after accept; mask matches the model.
- req_valid held high and req_block changed to all ones during ROUND → no second accept; m_block is unchanged; result matches the original block.
- reset_n low for 1 cycle during ROUND, counter = 5 → the next cycle shows IDLE, no strobe, req_ready = 1. A fresh job then completes correctly.
- res_ack delayed 7 cycles in DONE → res_valid and res_mask are stable throughout. IDLE follows the ack edge, and a second job is accepted the following cycle.
